fidus_reset_sequencer: RTL and testbench

//   Multi-domain reset controller. Holds NUM_DOMAINS active-low resets asserted,

---
 rtl/fidus_reset_sequencer_pkg.sv | 25 ++
 rtl/fidus_reset_cnt.sv | 50 +++++
 rtl/fidus_reset_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_fidus_reset_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fidus_reset_sequencer_pkg.sv
// Shared definitions for the multi-domain reset sequencer: state encoding,
// default timing values, message strings and a small parameter helper.
// No ports (package).
package fidus_reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } seq_state_e;

   localparam int unsigned DEF_HOLD_CYCLES = 16;
   localparam int unsigned DEF_GAP_CYCLES  = 8;

   localparam string MSG_RELEASE_FMT = "Domain %0d released";
   localparam string MSG_RUN         = "All domains released, sequence complete";
   localparam string MSG_REASSERT    = "Reset request: re-asserting all domains";

   // Zero-length hold/gap settings behave as a single cycle.
   function automatic int unsigned at_least_one(input int unsigned val);
      return (val == 0) ? 1 : val;
   endfunction

endpackage

// File: rtl/fidus_reset_cnt.sv
// Down-counter with synchronous clear/load, saturating at zero.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   clr_i         force count to zero (highest priority)
//   load_i        load load_val_i
//   load_val_i    value to load
//   cnt_o         registered count
//   zero_o        registered flag, high when cnt_o == 0
module fidus_reset_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q;

   // Next count: clear, load, or decrement toward zero and hold there.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Zero flag is registered alongside the count so it never lags it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= (cnt_d == '0);
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = zero_q;

endmodule

// File: rtl/fidus_reset_sequencer.sv
// Multi-domain reset sequencer. Holds all domain resets asserted, then
// releases them in index order with a minimum gap and a per-domain ready
// handshake. Any request re-asserts all domains and restarts the sequence.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset
//   i_rst_req        level reset requests (OR-reduced)
//   i_domain_ready   domain k ready, gates release of domain k+1
//   o_rst_n          registered active-low domain resets
//   o_busy / o_done  sequencing in progress / all domains released
//   o_seq_cnt        completed sequences, saturating
// Optional: define FIDUS_RST_SEQ_MSG_EN to emit simulation messages through
// sim_management_inst.printMessage; signal behaviour is unchanged.
module fidus_reset_sequencer
   import fidus_reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_DOMAINS = 4,
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int unsigned CNT_W       = 8,
   parameter string       BFM_NAME    = "bfm_reset_seq"
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_REQ-1:0]     i_rst_req,
   input  logic [NUM_DOMAINS-1:0] i_domain_ready,
   output logic [NUM_DOMAINS-1:0] o_rst_n,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [CNT_W-1:0]       o_seq_cnt
);

   localparam int unsigned      IDX_W     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam int unsigned      HOLD_EFF  = at_least_one(HOLD_CYCLES);
   localparam int unsigned      GAP_EFF   = at_least_one(GAP_CYCLES);
   // Hold checks zero one edge after reaching it; the gap load is one short
   // so that release spacing equals GAP_EFF exactly.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_EFF - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

   if (NUM_DOMAINS < 1 || NUM_REQ < 1) begin : g_bad_size
      $error("fidus_reset_sequencer: NUM_DOMAINS and NUM_REQ must be >= 1");
   end
   if ((HOLD_EFF >> CNT_W) != 0 || (GAP_EFF >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("fidus_reset_sequencer: HOLD/GAP do not fit in CNT_W bits");
   end
   if (BFM_NAME == "") begin : g_bad_name
      $error("fidus_reset_sequencer: BFM_NAME must not be empty");
   end

   seq_state_e             state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] rst_q, rst_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [CNT_W-1:0]       seq_cnt_q, seq_cnt_d;

   logic                   req_any;
   logic                   release_ok;
   logic                   hold_load, gap_load, cnt_clr, run_entry;
   logic                   hold_zero, gap_zero;
   logic [CNT_W-1:0]       hold_val, gap_val;
   logic                   unused_cnt_vals;

   assign req_any         = |i_rst_req;
   assign release_ok      = gap_zero & i_domain_ready[idx_q];
   assign unused_cnt_vals = ^{hold_val, gap_val};

   fidus_reset_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .clr_i      (cnt_clr),
      .load_i     (hold_load),
      .load_val_i (HOLD_LOAD),
      .cnt_o      (hold_val),
      .zero_o     (hold_zero)
   );

   fidus_reset_cnt #(.CNT_W(CNT_W)) u_gap_cnt (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .clr_i      (cnt_clr),
      .load_i     (gap_load),
      .load_val_i (GAP_LOAD),
      .cnt_o      (gap_val),
      .zero_o     (gap_zero)
   );

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_ASSERT;
         idx_q     <= '0;
         rst_q     <= '0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         seq_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rst_q     <= rst_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         seq_cnt_q <= seq_cnt_d;
      end
   end

   // Next state; a request always wins over release or RUN entry.
   always_comb begin
      state_d = state_q;
      if (req_any) begin
         state_d = ST_ASSERT;
      end else begin
         case (state_q)
            ST_ASSERT:  state_d = ST_HOLD;
            ST_HOLD:    if (hold_zero) state_d = ST_RELEASE;
            ST_RELEASE: if (release_ok && idx_q == LAST_IDX) state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_ASSERT;
         endcase
      end
   end

   // Next values of the registered outputs and counter controls.
   always_comb begin
      rst_d     = rst_q;
      idx_d     = idx_q;
      hold_load = 1'b0;
      gap_load  = 1'b0;
      cnt_clr   = 1'b0;
      run_entry = 1'b0;
      seq_cnt_d = seq_cnt_q;
      if (req_any) begin
         rst_d   = '0;
         idx_d   = '0;
         cnt_clr = 1'b1;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               rst_d     = '0;
               idx_d     = '0;
               hold_load = 1'b1;
            end
            ST_HOLD: begin
               if (hold_zero) begin
                  rst_d    = NUM_DOMAINS'(1);
                  idx_d    = '0;
                  gap_load = 1'b1;
               end
            end
            ST_RELEASE: begin
               if (release_ok) begin
                  if (idx_q == LAST_IDX) begin
                     run_entry = 1'b1;
                  end else begin
                     // Released domains are contiguous from 0: shift in one more.
                     rst_d    = NUM_DOMAINS'({rst_q, 1'b1});
                     idx_d    = idx_q + IDX_W'(1);
                     gap_load = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               rst_d = rst_q;
            end
            default: begin
               rst_d   = '0;
               idx_d   = '0;
               cnt_clr = 1'b1;
            end
         endcase
      end
      if (run_entry && seq_cnt_q != '1) begin
         seq_cnt_d = seq_cnt_q + CNT_W'(1);
      end
   end

   // Status flags follow the state being entered so they register with it.
   always_comb begin
      busy_d = (state_d != ST_RUN);
      done_d = (state_d == ST_RUN);
   end

   assign o_rst_n   = rst_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_seq_cnt = seq_cnt_q;

`ifdef FIDUS_RST_SEQ_MSG_EN
   // Simulation-only progress messages.
   always @(posedge i_clk) begin
      if (i_rst_n) begin
         if (req_any && state_q != ST_ASSERT) begin
            sim_management_inst.printMessage(BFM_NAME, MSG_REASSERT);
         end
         for (int k = 0; k < int'(NUM_DOMAINS); k++) begin
            if (rst_d[k] && !rst_q[k]) begin
               sim_management_inst.printMessage(BFM_NAME, $sformatf(MSG_RELEASE_FMT, k));
            end
         end
         if (run_entry && !req_any) begin
            sim_management_inst.printMessage(BFM_NAME, MSG_RUN);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fidus_reset_sequencer.sv
// Self-checking bench for fidus_reset_sequencer: directed scenarios plus a
// randomized phase, compared against a timestamp-based reference model.
// A second small instance covers the zero hold/gap, single-domain,
// narrow-counter configuration.
module tb_fidus_reset_sequencer;

   localparam int N = 4;
   localparam int H = 16;
   localparam int G = 8;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] req;
   logic [3:0] ready;
   logic [3:0] o_rst_n;
   logic       o_busy, o_done;
   logic [7:0] o_seq_cnt;

   logic       rst_n_b;
   logic [0:0] req_b;
   logic [0:0] ready_b;
   logic [0:0] o_rst_n_b;
   logic       o_busy_b, o_done_b;
   logic [1:0] o_seq_cnt_b;

   fidus_reset_sequencer u_dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_rst_req      (req),
      .i_domain_ready (ready),
      .o_rst_n        (o_rst_n),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_seq_cnt      (o_seq_cnt)
   );

   fidus_reset_sequencer #(
      .NUM_DOMAINS (1),
      .NUM_REQ     (1),
      .HOLD_CYCLES (0),
      .GAP_CYCLES  (0),
      .CNT_W       (2)
   ) u_dut_min (
      .i_clk          (clk),
      .i_rst_n        (rst_n_b),
      .i_rst_req      (req_b),
      .i_domain_ready (ready_b),
      .o_rst_n        (o_rst_n_b),
      .o_busy         (o_busy_b),
      .o_done         (o_done_b),
      .o_seq_cnt      (o_seq_cnt_b)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model: domains released count, completion and timestamps.
   int m_rel, m_done, m_cnt, t_quiet, t_last, e, last_edge;

   task automatic model_reset();
      m_rel = 0; m_done = 0; m_cnt = 0; t_quiet = -1; t_last = 0; e = 0; last_edge = -1;
   endtask

   // Applied once per rising edge, with the inputs sampled at that edge.
   task automatic model_edge();
      if (req != 2'b00) begin
         m_rel = 0; m_done = 0; t_quiet = -1;
      end else if (t_quiet < 0) begin
         t_quiet = e;
      end else if (m_rel == 0) begin
         if (e >= t_quiet + H + 1) begin
            m_rel = 1; t_last = e;
         end
      end else if (m_done == 0 && e >= t_last + G && ready[m_rel-1] == 1'b1) begin
         if (m_rel < N) begin
            m_rel++; t_last = e;
         end else begin
            m_done = 1;
            if (m_cnt < 255) m_cnt++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      last_edge = e;
      e++;
      #1;
      check_val("rst_n", 32'(o_rst_n), 32'((1 << m_rel) - 1));
      check_val("busy", 32'(o_busy), 32'(m_done == 0));
      check_val("done", 32'(o_done), 32'(m_done));
      check_val("seq_cnt", 32'(o_seq_cnt), 32'(m_cnt));
   endtask

   // Asynchronous reset pulse between edges; outputs must drop at once.
   task automatic rst_pulse(input string tag);
      rst_n = 1'b0;
      #2;
      check_val({tag, "_rst_n"}, 32'(o_rst_n), 32'h0);
      check_val({tag, "_busy"}, 32'(o_busy), 32'h1);
      check_val({tag, "_done"}, 32'(o_done), 32'h0);
      check_val({tag, "_cnt"}, 32'(o_seq_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   int p;
   int req_hold;

   initial begin
      rst_n = 1'b0; req = 2'b00; ready = 4'hF;
      rst_n_b = 1'b0; req_b = 1'b0; ready_b = 1'b1;
      req_hold = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("reset_rst_n", 32'(o_rst_n), 32'h0);
      check_val("reset_busy", 32'(o_busy), 32'h1);
      check_val("reset_done", 32'(o_done), 32'h0);
      check_val("reset_cnt", 32'(o_seq_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Default sequence with all domains ready.
      for (int i = 0; i < 60; i++) begin
         step();
         if (last_edge == 16) check_val("t1_e16", 32'(o_rst_n), 32'h0);
         if (last_edge == 17) check_val("t1_e17", 32'(o_rst_n), 32'h1);
         if (last_edge == 25) check_val("t1_e25", 32'(o_rst_n), 32'h3);
         if (last_edge == 33) check_val("t1_e33", 32'(o_rst_n), 32'h7);
         if (last_edge == 41) check_val("t1_e41", 32'(o_rst_n), 32'hF);
      end
      check_val("t1_cnt", 32'(o_seq_cnt), 32'h1);

      // One-clock request in RUN restarts with identical spacing.
      req = 2'b10;
      step();
      p = last_edge;
      check_val("t3_rst", 32'(o_rst_n), 32'h0);
      check_val("t3_done", 32'(o_done), 32'h0);
      req = 2'b00;
      for (int i = 0; i < 70; i++) begin
         step();
         if (last_edge == p + 17) check_val("t3_pre", 32'(o_rst_n), 32'h0);
         if (last_edge == p + 18) check_val("t3_d0", 32'(o_rst_n), 32'h1);
         if (last_edge == p + 42) check_val("t3_d3", 32'(o_rst_n), 32'hF);
      end
      check_val("t3_cnt", 32'(o_seq_cnt), 32'h2);

      // Async reset mid-RELEASE.
      rst_pulse("t6_run");
      for (int i = 0; i < 30; i++) step();
      ready[1] = 1'b0;
      rst_pulse("t6_mid");

      // Domain 1 ready held low until edge 60.
      for (int i = 0; i < 85; i++) begin
         step();
         if (last_edge == 60) begin
            check_val("t2_e60", 32'(o_rst_n), 32'h3);
            ready[1] = 1'b1;
         end
         if (last_edge == 61) check_val("t2_e61", 32'(o_rst_n), 32'h7);
         if (last_edge == 68) check_val("t2_e68", 32'(o_rst_n), 32'h7);
         if (last_edge == 69) check_val("t2_e69", 32'(o_rst_n), 32'hF);
      end

      // Request held 20 clocks starting on the edge domain 1 is due.
      rst_pulse("t4_start");
      for (int i = 0; i < 110; i++) begin
         step();
         if (last_edge == 24) begin
            check_val("t4_e24", 32'(o_rst_n), 32'h1);
            req = 2'b01;
         end
         if (last_edge == 25) check_val("t4_e25", 32'(o_rst_n), 32'h0);
         if (last_edge == 44) req = 2'b00;
         if (last_edge == 61) check_val("t4_e61", 32'(o_rst_n), 32'h0);
         if (last_edge == 62) check_val("t4_e62", 32'(o_rst_n), 32'h1);
      end

      // Randomized requests, ready levels and occasional async resets.
      for (int i = 0; i < 1500; i++) begin
         if (req_hold > 0) req_hold--;
         else req = 2'b00;
         if ($urandom_range(0, 99) == 0) begin
            req = 2'($urandom_range(1, 3));
            req_hold = int'($urandom_range(0, 5));
         end
         for (int b = 0; b < 4; b++) ready[b] = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 499) == 0) rst_pulse("rnd");
         step();
      end
      req = 2'b00;

      // Minimal configuration: zero hold/gap, one domain, 2-bit counter.
      check_val("t5_reset_rst", 32'(o_rst_n_b), 32'h0);
      check_val("t5_reset_busy", 32'(o_busy_b), 32'h1);
      @(negedge clk);
      rst_n_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         check_val("t5_rst", 32'(o_rst_n_b), (k >= 2) ? 32'h1 : 32'h0);
         check_val("t5_done", 32'(o_done_b), (k >= 3) ? 32'h1 : 32'h0);
      end
      check_val("t5_cnt1", 32'(o_seq_cnt_b), 32'h1);
      for (int s = 2; s <= 5; s++) begin
         @(negedge clk);
         req_b = 1'b1;
         @(posedge clk);
         #1;
         check_val("t5_req_rst", 32'(o_rst_n_b), 32'h0);
         check_val("t5_req_done", 32'(o_done_b), 32'h0);
         @(negedge clk);
         req_b = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         check_val("t5_seq_done", 32'(o_done_b), 32'h1);
         check_val("t5_seq_cnt", 32'(o_seq_cnt_b), (s >= 3) ? 32'h3 : 32'(s));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
